// File: rtl/if_id_queue_pkg.sv
// Shared IF->ID definitions: default widths, bubble constant and the queue entry type
// also used by downstream decode.
package if_id_pkg;

  localparam int unsigned IF_ID_ADDR_W = 32;
  localparam int unsigned IF_ID_INST_W = 32;

  localparam logic [31:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [IF_ID_ADDR_W-1:0] pc;
    logic [IF_ID_INST_W-1:0] inst;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF->ID queue.
// The slave modport is the queue itself; master is the fetch/decode environment.
interface if_id_queue_if
  import if_id_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ID_ADDR_W,
  parameter int unsigned INST_W = IF_ID_INST_W
);

  logic              if_valid_in;
  logic [ADDR_W-1:0] if_pc_in;
  logic [INST_W-1:0] if_inst_in;
  logic              if_ready_out;
  logic              id_ready_in;
  logic              id_valid_out;
  logic [ADDR_W-1:0] id_pc_out;
  logic [INST_W-1:0] id_inst_out;

  modport slave (
    input  if_valid_in, if_pc_in, if_inst_in, id_ready_in,
    output if_ready_out, id_valid_out, id_pc_out, id_inst_out
  );

  modport master (
    output if_valid_in, if_pc_in, if_inst_in, id_ready_in,
    input  if_ready_out, id_valid_out, id_pc_out, id_inst_out
  );

endinterface

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry in-order FIFO of {pc, inst} with one-cycle flush.
// Optional IF_ID_FLUSH_STATS_EN adds flushed_cnt_out, a saturating count of discarded entries.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ID_ADDR_W,
  parameter int unsigned INST_W = IF_ID_INST_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  if_id_queue_if.slave     bus,
`ifdef IF_ID_FLUSH_STATS_EN
  output logic [15:0]      flushed_cnt_out,
`endif
  output logic [CNT_W-1:0] count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if_id_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on registered state and storage.
  always_comb begin
    bus.if_ready_out = (count != FULL);
    bus.id_valid_out = (count != '0);
    bus.id_pc_out    = ADDR_W'(ZERO_WORD);
    bus.id_inst_out  = INST_W'(ZERO_WORD);
    if (count != '0) begin
      bus.id_pc_out   = mem[rd_ptr].pc;
      bus.id_inst_out = mem[rd_ptr].inst;
    end
  end

  assign push      = bus.if_valid_in & bus.if_ready_out;
  assign pop       = bus.id_valid_out & bus.id_ready_in;
  assign count_out = count;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; a flushed or reset-cycle push must not land.
  always_ff @(posedge clk_in) begin
    if (rst_in && !flush_in && push) begin
      mem[wr_ptr].pc   <= bus.if_pc_in;
      mem[wr_ptr].inst <= bus.if_inst_in;
    end
  end

`ifdef IF_ID_FLUSH_STATS_EN
  logic [16:0] flush_sum;

  always_comb flush_sum = 17'(flushed_cnt_out) + 17'(count) + 17'(push);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      flushed_cnt_out <= '0;
    end else if (flush_in) begin
      flushed_cnt_out <= flush_sum[16] ? '1 : flush_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             flush_in;
  logic [CNT_W-1:0] count_out;
`ifdef IF_ID_FLUSH_STATS_EN
  logic [15:0]      flushed_cnt_out;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  ent_t        mq[$];
  int unsigned m_flushed = 0;

  if_id_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .bus             (bus),
`ifdef IF_ID_FLUSH_STATS_EN
    .flushed_cnt_out (flushed_cnt_out),
`endif
    .count_out       (count_out)
  );

  always #5 clk_in = ~clk_in;

  // One clock of stimulus; the model applies the queue rules to the pre-edge occupancy.
  task automatic cycle(input logic rst, input logic fl, input logic v,
                       input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
    bit   push, pop;
    ent_t e;
    rst_in          = rst;
    flush_in        = fl;
    bus.if_valid_in = v;
    bus.if_pc_in    = pc;
    bus.if_inst_in  = inst;
    bus.id_ready_in = rdy;
    push = v && (mq.size() != DEPTH);
    pop  = rdy && (mq.size() != 0);
    @(posedge clk_in);
    #1;
    if (!rst) begin
      mq.delete();
      m_flushed = 0;
    end else if (fl) begin
      m_flushed = m_flushed + mq.size() + (push ? 1 : 0);
      if (m_flushed > 65535) m_flushed = 65535;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc   = pc;
        e.inst = inst;
        mq.push_back(e);
      end
    end
  endtask

  function automatic logic [69:0] exp_snap();
    logic [31:0] pc, inst;
    pc   = '0;
    inst = '0;
    if (mq.size() != 0) begin
      pc   = mq[0].pc;
      inst = mq[0].inst;
    end
    return {CNT_W'(mq.size()), mq.size() != 0, mq.size() != DEPTH, pc, inst};
  endfunction

  function automatic logic [69:0] act_snap();
    return {count_out, bus.id_valid_out, bus.if_ready_out, bus.id_pc_out, bus.id_inst_out};
  endfunction

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 32'h13, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h44, 32'h13, 1'b0);
    checks++;
    if ({count_out, bus.id_valid_out, bus.id_pc_out, bus.id_inst_out, bus.if_ready_out} !== {3'd0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset: cnt=%0d vld=%b pc=%h inst=%h rdy=%b required cnt=0 vld=0 pc=0 inst=0 rdy=1",
               count_out, bus.id_valid_out, bus.id_pc_out, bus.id_inst_out, bus.if_ready_out);
    end
  endtask

  task automatic test_in_order();
    logic [31:0] pcs [4];
    pcs = '{32'h100, 32'h104, 32'h108, 32'h0};
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h13, 1'b0);
    checks++;
    if (count_out !== 3'd3) begin
      errors++;
      $display("FAIL in_order_count: got %0d required 3", count_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.id_pc_out !== pcs[i] || bus.id_valid_out !== (i < 3)) begin
        errors++;
        $display("FAIL in_order_pc[%0d]: got pc=%h vld=%b required pc=%h vld=%b",
                 i, bus.id_pc_out, bus.id_valid_out, pcs[i], (i < 3));
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    checks++;
    if (bus.if_ready_out !== 1'b0 || count_out !== 3'd4) begin
      errors++;
      $display("FAIL full: got rdy=%b cnt=%0d required rdy=0 cnt=4", bus.if_ready_out, count_out);
    end
    cycle(1'b1, 1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 1'b0);
    checks++;
    if (act_snap() !== exp_snap() || count_out !== 3'd4 || bus.id_pc_out !== 32'h400) begin
      errors++;
      $display("FAIL full_ignore: got %h required %h", act_snap(), exp_snap());
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (bus.if_ready_out !== 1'b1 || count_out !== 3'd3) begin
      errors++;
      $display("FAIL full_pop: got rdy=%b cnt=%0d required rdy=1 cnt=3", bus.if_ready_out, count_out);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1);
      checks++;
      if (act_snap() !== exp_snap() || count_out !== 3'd2) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h required %h", i, act_snap(), exp_snap());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    prev = bus.id_pc_out;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 32'h600 + 32'(4 * i), 32'h13, 1'b1);
      checks++;
      if (count_out !== 3'd2 || bus.id_pc_out <= prev || act_snap() !== exp_snap()) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got cnt=%0d pc=%h prev=%h snap=%h required cnt=2 snap=%h",
                 i, count_out, bus.id_pc_out, prev, act_snap(), exp_snap());
      end
      prev = bus.id_pc_out;
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'h13, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h200, 32'h13, 1'b0);
    checks++;
    if (count_out !== 3'd0 || bus.id_pc_out !== 32'h0 || bus.id_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush: got cnt=%0d pc=%h vld=%b required cnt=0 pc=0 vld=0",
               count_out, bus.id_pc_out, bus.id_valid_out);
    end
`ifdef IF_ID_FLUSH_STATS_EN
    checks++;
    if (flushed_cnt_out !== 16'd4) begin
      errors++;
      $display("FAIL flush_stats: got %0d required 4", flushed_cnt_out);
    end
`endif
    cycle(1'b1, 1'b0, 1'b1, 32'h220, 32'h13, 1'b0);
    checks++;
    if (bus.id_pc_out !== 32'h220 || count_out !== 3'd1) begin
      errors++;
      $display("FAIL flush_no_leak: got pc=%h cnt=%0d required pc=00000220 cnt=1", bus.id_pc_out, count_out);
    end
  endtask

  task automatic test_reset_flush();
    cycle(1'b1, 1'b0, 1'b1, 32'h2A0, 32'h13, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h2A4, 32'h13, 1'b0);
    checks++;
    if ({count_out, bus.id_valid_out, bus.id_pc_out, bus.if_ready_out} !== {3'd0, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_flush: got cnt=%0d vld=%b pc=%h rdy=%b required cnt=0 vld=0 pc=0 rdy=1",
               count_out, bus.id_valid_out, bus.id_pc_out, bus.if_ready_out);
    end
`ifdef IF_ID_FLUSH_STATS_EN
    checks++;
    if (flushed_cnt_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_flush_stats: got %0d required 0", flushed_cnt_out);
    end
`endif
    cycle(1'b1, 1'b0, 1'b1, 32'h300, 32'hABCD, 1'b0);
    checks++;
    if (bus.id_pc_out !== 32'h300 || bus.id_inst_out !== 32'hABCD) begin
      errors++;
      $display("FAIL post_reset_push: got pc=%h inst=%h required pc=00000300 inst=0000abcd",
               bus.id_pc_out, bus.id_inst_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) != 0), ($urandom_range(15) == 0), $urandom_range(1) == 1,
            $urandom, $urandom, $urandom_range(2) != 0);
      checks++;
      if (act_snap() !== exp_snap()) begin
        errors++;
        $display("FAIL random[%0d]: got %h required %h", i, act_snap(), exp_snap());
      end
`ifdef IF_ID_FLUSH_STATS_EN
      checks++;
      if (flushed_cnt_out !== 16'(m_flushed)) begin
        errors++;
        $display("FAIL random_stats[%0d]: got %0d required %0d", i, flushed_cnt_out, m_flushed);
      end
`endif
    end
  endtask

  initial begin
    rst_in          = 1'b0;
    flush_in        = 1'b0;
    bus.if_valid_in = 1'b0;
    bus.if_pc_in    = '0;
    bus.if_inst_in  = '0;
    bus.id_ready_in = 1'b0;
    test_reset();
    test_in_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF→ID decoupling stage: a DEPTH-entry in-order queue of {pc, inst} pairs between fetch and decode.
- Replaces a single-register stage with a valid/ready handshake, so fetch can run ahead while decode stalls.
- A branch flush discards every queued entry in one cycle.
- An empty queue presents a zero bubble (pc = 0, inst = 0) to decode.

Parameters:
- ADDR_W, 32, pc width.
- INST_W, 32, instruction width.
- DEPTH, 4, entry count; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived localparam).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-low reset.
- flush_in  input  1  branch/flush: discard all entries this cycle.
- if_valid_in  input  1  fetch presents an entry.
- if_pc_in  input  ADDR_W  fetched pc.
- if_inst_in  input  INST_W  fetched instruction.
- if_ready_out  output  1  queue can accept an entry.
- id_ready_in  input  1  decode accepts the head entry (low = decode stalled).
- id_valid_out  output  1  head entry is valid.
- id_pc_out  output  ADDR_W  head pc; 0 when empty.
- id_inst_out  output  INST_W  head instruction; 0 when empty.
- count_out  output  CNT_W  current occupancy.

Behaviour:
- Reset (rst_in == 0 at clk edge): wr_ptr = 0, rd_ptr = 0, count = 0.
  - Resulting outputs: id_valid_out = 0, id_pc_out = 0, id_inst_out = 0, if_ready_out = 1, count_out = 0.
  - Storage contents are not reset.
  - Reset overrides flush, push and pop in the same cycle.
- push = if_valid_in & if_ready_out; pop = id_valid_out & id_ready_in.
- if_ready_out = (count != DEPTH). It is a function of registered state only; there is no combinational path from id_ready_in.
- id_valid_out = (count != 0). id_pc_out/id_inst_out = mem[rd_ptr] when valid, else zero. These are driven from registers/storage only; there is no path from the if_* inputs.
- Latency: a pushed entry is visible at the outputs on the cycle after the push. There is no same-cycle bypass, even when the queue is empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. count is tracked separately and gives the full/empty distinction.
- Push only: mem[wr_ptr] written, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count−1.
- Push and pop in the same cycle: both pointers advance, count unchanged. This is legal at any occupancy 1..DEPTH−1.
  - Full: no push occurs (if_ready_out = 0).
  - Empty: no pop occurs (id_valid_out = 0).
- Flush (flush_in = 1):
  - Next state is wr_ptr = rd_ptr = 0, count = 0.
  - A push in the same cycle is discarded; no storage write takes effect.
  - A pop in the same cycle is still considered consumed by decode, with no further effect.
  - The cycle after a flush, outputs show the bubble.
- Priority: reset > flush > push/pop.
- if_valid_in while full: no effect. Fetch must hold its data until if_ready_out = 1.
- id_ready_in while empty: no effect.

Optional Feature:
- Macro: IF_ID_FLUSH_STATS_EN.
- Defined:
  - Adds output flushed_cnt_out [15:0], reset to 0.
  - On each flush cycle it adds count + (if_valid_in & if_ready_out), i.e. the number of entries discarded.
  - Saturates at 16'hFFFF.
  - Not affected by normal pops.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package if_id_pkg:
  - ZERO_WORD constant.
  - Default ADDR_W/INST_W.
  - Typedef if_id_entry_t {pc, inst} used for the storage array and by downstream decode.
- No sub-module. Storage, pointers and counter stay inline; the block is small enough to read as one unit.

Test Plan:
- Reset with rst_in = 0 for 2 cycles while if_valid_in = 1 → count_out = 0, id_valid_out = 0, outputs 0, if_ready_out = 1.
- Push pc = 0x100/0x104/0x108 (inst = 0x00000013) with id_ready_in = 0 → count_out = 3. Then id_ready_in = 1 → pcs appear in order 0x100, 0x104, 0x108 on consecutive cycles, then bubble.
- Fill DEPTH = 4 entries with decode stalled → if_ready_out = 0. A fifth if_valid_in is ignored. One pop → if_ready_out = 1 the next cycle. Pointer wrap verified over 10 push/pop pairs with continuous streaming at count = 2.
- Simultaneous push and pop at count = 2 for 8 cycles → count_out constant at 2, pcs strictly in order.
- flush_in = 1 with count = 3 and a concurrent push of pc = 0x200 → next cycle count_out = 0, id_pc_out = 0, 0x200 never appears. With IF_ID_FLUSH_STATS_EN defined, flushed_cnt_out = 4.
- flush_in and rst_in = 0 in the same cycle → reset state. Then push 0x300 with no flush → id_pc_out = 0x300 one cycle later.
